// File: rtl/ex_mem_loader_pkg.sv
// Shared types and header layout for the riscv external-memory boot loader.
// Header word: [8:0] start address, [24:16] beat count, all other bits reserved (must be 0).
package ex_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_RELEASE,
        ST_RUN
    } loader_state_e;

    typedef enum logic [1:0] {
        W_I1,
        W_I2,
        W_D1,
        W_D2
    } beat_word_e;

    localparam int          HDR_ADDR_LSB  = 0;
    localparam int          HDR_ADDR_MSB  = 8;
    localparam int          HDR_CNT_LSB   = 16;
    localparam int          HDR_CNT_MSB   = 24;
    localparam logic [31:0] HDR_RSVD_MASK = 32'hFE00_FE00;

endpackage

// File: rtl/ex_mem_beat_packer.sv
// Collects four consecutive stream words (I1, I2, D1, D2) into one load-port beat.
// A beat completes on the same edge that accepts its D2 word.
module ex_mem_beat_packer
    import ex_mem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              flush_i,
    input  logic              word_valid_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] i1_o,
    output logic [DATA_W-1:0] i2_o,
    output logic [DATA_W-1:0] d1_o,
    output logic [DATA_W-1:0] d2_o,
    output logic              beat_done_o
);

    beat_word_e        idx_q;
    logic [DATA_W-1:0] i1_q;
    logic [DATA_W-1:0] i2_q;
    logic [DATA_W-1:0] d1_q;

    always_ff @(posedge clk) begin
        if (flush_i) begin
            idx_q <= W_I1;
            i1_q  <= '0;
            i2_q  <= '0;
            d1_q  <= '0;
        end else if (word_valid_i) begin
            unique case (idx_q)
                W_I1: begin
                    i1_q  <= word_i;
                    idx_q <= W_I2;
                end
                W_I2: begin
                    i2_q  <= word_i;
                    idx_q <= W_D1;
                end
                W_D1: begin
                    d1_q  <= word_i;
                    idx_q <= W_D2;
                end
                W_D2: begin
                    idx_q <= W_I1;
                end
                default: idx_q <= W_I1;
            endcase
        end
    end

    // D2 is passed straight through so the parent can register the whole beat
    // on the accepting edge without an extra cycle of latency.
    assign i1_o        = i1_q;
    assign i2_o        = i2_q;
    assign d1_o        = d1_q;
    assign d2_o        = word_i;
    assign beat_done_o = word_valid_i && (idx_q == W_D2);

endmodule

// File: rtl/ex_mem_loader.sv
// Boot loader: parses a header, streams beats into the riscv external load port,
// then pulses the core reset and releases the core to run.
module ex_mem_loader
    import ex_mem_loader_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              restart,
    output logic              core_reset,
    output logic              enable_load_ex_mem,
    output logic [ADDR_W-1:0] InstExMemAddress,
    output logic [ADDR_W-1:0] DataExMemAddress,
    output logic [DATA_W-1:0] InstExMemData1,
    output logic [DATA_W-1:0] InstExMemData2,
    output logic [DATA_W-1:0] DataExMemData1,
    output logic [DATA_W-1:0] DataExMemData2,
    output logic              running,
    output logic              err
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    loader_state_e     state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [8:0]        k_q;
    logic [8:0]        n_q;
    logic [RC_W-1:0]   rst_cnt_q;

    logic              s_ready_q;
    logic              core_reset_q;
    logic              en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] i1_q, i2_q, d1_q, d2_q;
    logic              running_q;
    logic              err_q;

    logic              accept;
    logic              pack_valid;
    logic              beat_done;
    logic [DATA_W-1:0] pk_i1, pk_i2, pk_d1, pk_d2;
    logic [ADDR_W-1:0] hdr_addr;
    logic [8:0]        hdr_cnt;
    logic              hdr_bad;

    assign accept     = s_valid && s_ready_q;
    assign pack_valid = accept && (state_q == ST_COLLECT);
    assign hdr_addr   = ADDR_W'(s_data[HDR_ADDR_MSB:HDR_ADDR_LSB]);
    assign hdr_cnt    = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
    assign hdr_bad    = |(s_data & DATA_W'(HDR_RSVD_MASK));

    ex_mem_beat_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk         (clk),
        .flush_i     (reset),
        .word_valid_i(pack_valid),
        .word_i      (s_data),
        .i1_o        (pk_i1),
        .i2_o        (pk_i2),
        .d1_o        (pk_d1),
        .d2_o        (pk_d2),
        .beat_done_o (beat_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            k_q          <= '0;
            n_q          <= '0;
            rst_cnt_q    <= '0;
            s_ready_q    <= 1'b1;
            core_reset_q <= 1'b1;
            en_q         <= 1'b0;
            addr_q       <= '0;
            i1_q         <= '0;
            i2_q         <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
            running_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            err_q <= 1'b1;
                        end else if (hdr_cnt != 9'd0) begin
                            state_q      <= ST_COLLECT;
                            core_reset_q <= 1'b0;
                            cur_addr_q   <= hdr_addr;
                            n_q          <= hdr_cnt;
                            k_q          <= '0;
                        end else begin
                            state_q   <= ST_RELEASE;
                            s_ready_q <= 1'b0;
                            rst_cnt_q <= '0;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (beat_done) begin
                        state_q   <= ST_WRITE;
                        s_ready_q <= 1'b0;
                        en_q      <= 1'b1;
                        addr_q    <= cur_addr_q;
                        i1_q      <= pk_i1;
                        i2_q      <= pk_i2;
                        d1_q      <= pk_d1;
                        d2_q      <= pk_d2;
                    end
                end
                ST_WRITE: begin
                    en_q <= 1'b0;
                    if (k_q == n_q - 9'd1) begin
                        state_q      <= ST_RELEASE;
                        core_reset_q <= 1'b1;
                        rst_cnt_q    <= '0;
                    end else begin
                        state_q    <= ST_COLLECT;
                        s_ready_q  <= 1'b1;
                        k_q        <= k_q + 9'd1;
                        cur_addr_q <= cur_addr_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                        state_q      <= ST_RUN;
                        core_reset_q <= 1'b0;
                        running_q    <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (restart) begin
                        state_q      <= ST_IDLE;
                        core_reset_q <= 1'b1;
                        running_q    <= 1'b0;
                        err_q        <= 1'b0;
                        s_ready_q    <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready            = s_ready_q;
    assign core_reset         = core_reset_q;
    assign enable_load_ex_mem = en_q;
    assign InstExMemAddress   = addr_q;
    assign DataExMemAddress   = addr_q;
    assign InstExMemData1     = i1_q;
    assign InstExMemData2     = i2_q;
    assign DataExMemData1     = d1_q;
    assign DataExMemData2     = d2_q;
    assign running            = running_q;
    assign err                = err_q;

endmodule

// File: doc/ex_mem_loader.md
# ex_mem_loader

Hardware boot loader that drives the `riscv` core's external memory load port (`enable_load_ex_mem`, Inst/Data address and word pairs). It consumes a valid/ready 32-bit word stream holding a header followed by program/data payload and writes it into instruction and data memory one beat per write cycle. It then pulses the core reset and releases the core to run. It sits between a host/UART/ROM word source and the `riscv` top, replacing the hand-driven load sequence used in simulation.

## Interface
- `ADDR_W`, 9: width of `InstExMemAddress` / `DataExMemAddress`.
- `DATA_W`, 32: width of each memory data word and of the stream.
- `RST_CYCLES`, 2: length, in cycles, of the core reset pulse after loading (≥1).
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader accepts word; transfer occurs when `s_valid && s_ready`.
- `s_data`  in  DATA_W  stream word.
- `restart`  in  1  single-cycle request: return from RUN to IDLE for reload.
- `core_reset`  out  1  drives the core's `reset`.
- `enable_load_ex_mem`  out  1  load-port write strobe.
- `InstExMemAddress`, `DataExMemAddress`  out  ADDR_W  beat address; both carry the same value.
- `InstExMemData1`, `InstExMemData2`, `DataExMemData1`, `DataExMemData2`  out  DATA_W  beat payload.
- `running`  out  1  core has been released.
- `err`  out  1  sticky malformed-header flag.

## Operation
- Header word: `[8:0]` = start address S, `[24:16]` = beat count N (0..511), all other bits reserved and required to be 0.
- Payload: 4·N words, per beat in order I1, I2, D1, D2.
  - Beat k is written at address (S+k) mod 2^ADDR_W; wrap-around is silent.
- States:
  - IDLE: `core_reset`=1, `s_ready`=1.
    - Valid header with N>0 → COLLECT, with `core_reset`=0.
    - Valid header with N=0 → RELEASE.
    - Header with nonzero reserved bits: word dropped, `err`←1, stay IDLE.
  - COLLECT: `s_ready`=1, `core_reset`=0. Words fill I1, I2, D1, D2 registers in order. The 4th accepted word → WRITE.
  - WRITE: exactly one cycle. `enable_load_ex_mem`=1, `s_ready`=0, address = S+k.
    - If k = N−1 → RELEASE; else k++ → COLLECT.
  - RELEASE: `core_reset`=1 for RST_CYCLES cycles, `s_ready`=0 → RUN.
  - RUN: `core_reset`=0, `running`=1, `s_ready`=0. `restart`=1 → IDLE.
- `err` is cleared by `reset` or by `restart`. An error never aborts a load in progress, because headers are only parsed in IDLE.
- `s_valid` low in COLLECT stalls collection indefinitely. Partial beat registers hold their values.
- `reset` at any time, including mid-beat or mid-RELEASE: next cycle is IDLE. Partial beat is discarded, beat counter is cleared, no write strobe is issued.
- `restart` outside RUN is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `core_reset`=1, `s_ready`=1 (IDLE)
  - `enable_load_ex_mem`=0
  - addresses and data = 0
  - `running`=0, `err`=0
- Header accepted at edge t → COLLECT from cycle t+1 (`core_reset` low from t+1).
- 4th payload word accepted at edge t → `enable_load_ex_mem` high during cycle t+1 only, with address/data stable. `s_ready` is low during that same cycle.
- Sustained throughput: 5 cycles per beat.
- Address and data outputs hold their last written values when not strobing.
- Last WRITE in cycle t → `core_reset` high cycles t+1..t+RST_CYCLES → `running`=1 and `core_reset`=0 from t+RST_CYCLES+1.
- `restart` sampled at edge t in RUN → cycle t+1: IDLE, `core_reset`=1, `running`=0, `err`=0.

## Structure
- `ex_mem_loader_pkg`:
  - state enum (IDLE, COLLECT, WRITE, RELEASE, RUN)
  - header field localparams (address LSB/MSB, count LSB/MSB, reserved mask)
  - beat word-index enum
- One natural sub-module: `ex_mem_beat_packer`. It is the 4-word collector with a word index, a beat-complete pulse and a flush on reset. The FSM, address/beat counters and reset-pulse counter stay in `ex_mem_loader`.

## Test plan
- Single beat, matching the core's bring-up program:
  - Stimulus: header 0x0001_0000, then 0x0010_0393, 0x0003_8303, 0x0000_8F00, 0x0000_00FF.
  - Response: exactly one strobe cycle with address 0 and those four values on I1/I2/D1/D2. Then `core_reset` high 2 cycles, then `running`=1.
- Wrap: header S=510, N=3 → strobes at addresses 510, 511, 0, in order.
- Stall: `s_valid` toggled at random between words → identical strobe sequence, no extra strobes, `s_ready` low in every strobe cycle.
- Error and N=0:
  - Header 0x8000_0000 → `err`=1, state stays IDLE.
  - Then header 0x0000_0000 → RELEASE then RUN with zero strobes, `err` still 1 until `restart`.
- Reset after 2 of 4 payload words → no strobe. Fresh header plus 4 words → single strobe with the new data only.
- Reload: in RUN, pulse `restart`, then a second image → `core_reset` high through IDLE, second image written, `running` returns to 1.
